redmule_castout_stream: RTL and testbench
=========================================

// Module: redmule_castout_stream
// PURPOSE
//  Streaming, back-pressured output cast/pack stage between the RedMulE
//  Z-buffer and the HCI store streamer. Two modes: pass FP16 beats through
//  unchanged, or down-cast FP16->FP8 (E5M2) and pack two input beats into one
//  output beat, halving store traffic. Adds a valid/ready handshake, optional
//  pipelining, packet-tail handling and byte strobes.
// PARAMETERS
//  DATA_W     256  beat width in bits; must be a multiple of 32
//  PIPE_REGS  1    cast-stage register count (0 or 1)
// PORTS
//  clk_i        in   1         clock
//  rst_ni       in   1         async reset, active low
//  clear_i      in   1         sync clear: drop all held data, return to EMPTY
//  cast_en_i    in   1         1: cast+pack; 0: passthrough. Latched at packet start
//  src_valid_i  in   1         input beat valid
//  src_ready_o  out  1         input beat accepted when valid&ready
//  src_data_i   in   DATA_W    DATA_W/16 FP16 lanes, lane 0 at LSBs
//  src_last_i   in   1         final beat of packet
//  dst_valid_o  out  1         output beat valid
//  dst_ready_i  in   1         downstream accepts
//  dst_data_o   out  DATA_W    output beat
//  dst_strb_o   out  DATA_W/8  byte enables of dst_data_o
//  dst_last_o   out  1         final beat of packet
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low (clk_i, rst_ni).
//  - Reset/clear: dst_valid_o=0, dst_data_o=0, dst_strb_o=0, dst_last_o=0,
//    pack state EMPTY, mode latch=0. clear_i wins over any same-cycle handshake.
//  - Mode latch: cast_en_i sampled on first accepted beat of a packet (state
//    EMPTY and no packet open); held until the beat with src_last_i is accepted.
//  - Lane cast x[15:0]->y[7:0]: NaN (x[14:10]=31, x[9:0]!=0) -> 0x7E|x[15]<<7;
//    else y = x[15:8] + (x[7] & (x[8] | |x[6:0])) (RNE; carry naturally yields
//    inf 0x7C/0xFC on overflow; inf and subnormals handled by same rule).
//  - Cast stage: PIPE_REGS=1 registers the cast lanes with valid; stage stalls
//    when its output is not consumed. PIPE_REGS=0 is combinational.
//  - Passthrough: each input beat -> one output beat, data unchanged, strb all 1s,
//    dst_last_o = src_last_i.
//  - Pack FSM (cast mode): EMPTY --beat, !last--> HALF (cast lanes stored in low
//    half buffer); EMPTY --beat, last--> emit {zeros, cast} strb low half only,
//    last=1; HALF --beat--> emit {cast_new, held}, strb all 1s, last=src_last;
//    -> EMPTY.
//  - Output register: single entry plus one-entry skid; src_ready_o is
//    registered (no comb path dst_ready_i->src_ready_o). dst_* stable while
//    dst_valid_o & !dst_ready_i.
//  - Latency (no stall): passthrough 1+PIPE_REGS cycles; packed beat appears
//    1+PIPE_REGS cycles after the second input beat.
//  - Throughput: 1 beat/cycle in, 1 beat/cycle (passthrough) or 1 per 2 (cast) out.
//  - cast_en_i changes mid-packet are ignored. Reset mid-packet discards the
//    half buffer; no partial beat is emitted.
// TESTING
//  - Cast 4 beats, all lanes 0x3C00 -> 2 beats, all bytes 0x3C, strb all 1s,
//    last on 2nd.
//  - Rounding lanes 0x3C80,0x3D80,0x7BFF,0x7E00,0xFC00 -> 0x3C,0x3E,0x7C,0x7E,0xFC.
//  - Cast 3-beat packet -> beat 2 strb low DATA_W/16 bytes only, upper data 0,
//    last=1.
//  - Passthrough with random dst_ready_i 50% -> output equals input in order,
//    no loss/dup.
//  - cast_en_i toggled mid-packet -> mode unchanged until after last beat.
//  - clear_i while in HALF with dst_valid_o high -> next cycle dst_valid_o=0;
//    next packet starts at EMPTY.

Source files
------------

// File: rtl/redmule_castout_stream.sv
// Output cast/pack stage between the RedMulE Z-buffer and the store streamer.
// FP16 beats pass through, or are down-cast to FP8 (E5M2) and packed two-to-one.
module redmule_castout_stream #(
    parameter int DATA_W    = 256,
    parameter int PIPE_REGS = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                cast_en_i,
    input  logic                src_valid_i,
    output logic                src_ready_o,
    input  logic [DATA_W-1:0]   src_data_i,
    input  logic                src_last_i,
    output logic                dst_valid_o,
    input  logic                dst_ready_i,
    output logic [DATA_W-1:0]   dst_data_o,
    output logic [DATA_W/8-1:0] dst_strb_o,
    output logic                dst_last_o
);
    localparam int NL = DATA_W / 16;
    localparam int HW = DATA_W / 2;
    localparam int SW = DATA_W / 8;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_HALF  = 1'b1;

    // Handshake: a beat moves on either port only in a cycle where valid and
    // ready are both high at the rising edge; a raised valid is held, with its
    // payload unchanged, until that happens. src_ready_o is a flop.

    // RNE truncation of the low mantissa byte; NaN is forced quiet so that
    // rounding can never turn it into an infinity.
    function automatic logic [7:0] cast_lane(input logic [15:0] x);
        logic [7:0] y;
        if ((x[14:10] == 5'h1f) && (x[9:0] != 10'd0)) begin
            y = {x[15], 7'h7E};
        end else begin
            y = x[15:8] + {7'd0, x[7] & (x[8] | (|x[6:0]))};
        end
        return y;
    endfunction

    logic              src_ready_q;
    logic              src_fire;
    logic              pkt_open_q;
    logic              mode_q;
    logic              beat_mode;
    logic [HW-1:0]     cast_in;

    logic              item_valid;
    logic [DATA_W-1:0] item_data;
    logic [HW-1:0]     item_cast;
    logic              item_last;
    logic              item_mode;
    logic              stg_free_d;

    logic [0:0]        state_q, state_d;
    logic [HW-1:0]     half_q, half_d;
    logic              advance;
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic [SW-1:0]     push_strb;
    logic              push_last;

    logic              out_valid_q, skid_valid_q;
    logic [DATA_W-1:0] out_data_q, skid_data_q;
    logic [SW-1:0]     out_strb_q, skid_strb_q;
    logic              out_last_q, skid_last_q;
    logic              pop;
    logic              full;
    logic [1:0]        cnt, cnt_d;
    logic              ready_d;

    assign src_ready_o = src_ready_q;
    assign src_fire    = src_valid_i & src_ready_q;
    assign beat_mode   = pkt_open_q ? mode_q : cast_en_i;

    always_comb begin
        cast_in = '0;
        for (int i = 0; i < NL; i++) begin
            cast_in[8*i +: 8] = cast_lane(src_data_i[16*i +: 16]);
        end
    end

    // Mode is captured on the opening beat and held until the tail is taken.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pkt_open_q <= 1'b0;
            mode_q     <= 1'b0;
        end else if (clear_i) begin
            pkt_open_q <= 1'b0;
            mode_q     <= 1'b0;
        end else if (src_fire) begin
            if (!pkt_open_q) begin
                mode_q <= cast_en_i;
            end
            pkt_open_q <= ~src_last_i;
        end
    end

    assign pop     = out_valid_q & dst_ready_i;
    assign full    = out_valid_q & skid_valid_q;
    assign advance = item_valid & (~full | pop);

    generate
        if (PIPE_REGS != 0) begin : g_pipe
            logic              stg_valid;
            logic [DATA_W-1:0] stg_data;
            logic [HW-1:0]     stg_cast;
            logic              stg_last;
            logic              stg_mode;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    stg_valid <= 1'b0;
                    stg_data  <= '0;
                    stg_cast  <= '0;
                    stg_last  <= 1'b0;
                    stg_mode  <= 1'b0;
                end else if (clear_i) begin
                    stg_valid <= 1'b0;
                end else if (src_fire) begin
                    stg_valid <= 1'b1;
                    stg_data  <= src_data_i;
                    stg_cast  <= cast_in;
                    stg_last  <= src_last_i;
                    stg_mode  <= beat_mode;
                end else if (advance) begin
                    stg_valid <= 1'b0;
                end
            end

            assign item_valid = stg_valid;
            assign item_data  = stg_data;
            assign item_cast  = stg_cast;
            assign item_last  = stg_last;
            assign item_mode  = stg_mode;
            assign stg_free_d = ~(src_fire | (stg_valid & ~advance));
        end else begin : g_comb
            assign item_valid = src_fire;
            assign item_data  = src_data_i;
            assign item_cast  = cast_in;
            assign item_last  = src_last_i;
            assign item_mode  = beat_mode;
            assign stg_free_d = 1'b0;
        end
    endgenerate

    always_comb begin
        push      = 1'b0;
        push_data = '0;
        push_strb = '0;
        push_last = 1'b0;
        state_d   = state_q;
        half_d    = half_q;
        if (advance) begin
            if (!item_mode) begin
                push      = 1'b1;
                push_data = item_data;
                push_strb = '1;
                push_last = item_last;
            end else if (state_q == ST_HALF) begin
                push      = 1'b1;
                push_data = {item_cast, half_q};
                push_strb = '1;
                push_last = item_last;
                state_d   = ST_EMPTY;
            end else if (item_last) begin
                push      = 1'b1;
                push_data = {{HW{1'b0}}, item_cast};
                push_strb = {{(SW/2){1'b0}}, {(SW/2){1'b1}}};
                push_last = 1'b1;
            end else begin
                state_d = ST_HALF;
                half_d  = item_cast;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_EMPTY;
            half_q  <= '0;
        end else if (clear_i) begin
            state_q <= ST_EMPTY;
            half_q  <= '0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
        end
    end

    // Main output register plus one skid entry; push into a full pair only
    // happens together with a pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_strb_q   <= '0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_strb_q  <= '0;
            skid_last_q  <= 1'b0;
        end else if (clear_i) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_strb_q   <= '0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_strb_q  <= '0;
            skid_last_q  <= 1'b0;
        end else if (pop) begin
            if (skid_valid_q) begin
                out_data_q <= skid_data_q;
                out_strb_q <= skid_strb_q;
                out_last_q <= skid_last_q;
                if (push) begin
                    skid_data_q <= push_data;
                    skid_strb_q <= push_strb;
                    skid_last_q <= push_last;
                end else begin
                    skid_valid_q <= 1'b0;
                end
            end else if (push) begin
                out_data_q <= push_data;
                out_strb_q <= push_strb;
                out_last_q <= push_last;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (push) begin
            if (out_valid_q) begin
                skid_valid_q <= 1'b1;
                skid_data_q  <= push_data;
                skid_strb_q  <= push_strb;
                skid_last_q  <= push_last;
            end else begin
                out_valid_q <= 1'b1;
                out_data_q  <= push_data;
                out_strb_q  <= push_strb;
                out_last_q  <= push_last;
            end
        end
    end

    // Ready for next cycle only if a beat taken then is guaranteed a slot.
    assign cnt     = {1'b0, out_valid_q} + {1'b0, skid_valid_q};
    assign cnt_d   = cnt + {1'b0, push} - {1'b0, pop};
    assign ready_d = (cnt_d < 2'd2) | stg_free_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_ready_q <= 1'b1;
        end else if (clear_i) begin
            src_ready_q <= 1'b1;
        end else begin
            src_ready_q <= ready_d;
        end
    end

    assign dst_valid_o = out_valid_q;
    assign dst_data_o  = out_data_q;
    assign dst_strb_o  = out_strb_q;
    assign dst_last_o  = out_last_q;

endmodule

// File: tb/tb_redmule_castout_stream.sv
// Directed bench for redmule_castout_stream: cast/pack, rounding, tails,
// passthrough under back-pressure, mid-packet mode changes and clear.
module tb_redmule_castout_stream;
    localparam int W  = 256;
    localparam int SW = W / 8;
    localparam int HW = W / 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          cast_en = 1'b0;
    logic          src_valid = 1'b0;
    logic          src_ready;
    logic [W-1:0]  src_data = '0;
    logic          src_last = 1'b0;
    logic          dst_valid;
    logic          dst_ready = 1'b1;
    logic [W-1:0]  dst_data;
    logic [SW-1:0] dst_strb;
    logic          dst_last;

    int vectors = 0;
    int miscompares = 0;
    int ready_mode = 0;

    logic [W-1:0]  exp_q[$];
    logic [SW-1:0] exp_strb_q[$];
    logic          exp_last_q[$];
    logic [W-1:0]  got_q[$];
    logic [SW-1:0] got_strb_q[$];
    logic          got_last_q[$];

    redmule_castout_stream #(.DATA_W(W), .PIPE_REGS(1)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .clear_i    (clear),
        .cast_en_i  (cast_en),
        .src_valid_i(src_valid),
        .src_ready_o(src_ready),
        .src_data_i (src_data),
        .src_last_i (src_last),
        .dst_valid_o(dst_valid),
        .dst_ready_i(dst_ready),
        .dst_data_o (dst_data),
        .dst_strb_o (dst_strb),
        .dst_last_o (dst_last)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] fill16(input logic [15:0] v);
        return {(W/16){v}};
    endfunction

    function automatic logic [HW-1:0] fill8(input logic [7:0] v);
        return {(HW/8){v}};
    endfunction

    // Sink: pick dst_ready for the coming edge, then log the handshake it makes.
    always @(negedge clk) begin
        case (ready_mode)
            0:       dst_ready = 1'b1;
            1:       dst_ready = 1'($urandom_range(0, 1));
            default: dst_ready = 1'b0;
        endcase
        if (rst_n && dst_valid && dst_ready) begin
            got_q.push_back(dst_data);
            got_strb_q.push_back(dst_strb);
            got_last_q.push_back(dst_last);
        end
    end

    task automatic send(input logic [W-1:0] d, input logic l, input logic c);
        int n;
        n = 0;
        src_valid = 1'b1;
        src_data  = d;
        src_last  = l;
        cast_en   = c;
        while (!src_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_vec("src_ready_wait", W'(n >= 200), '0);
        @(negedge clk);
        src_valid = 1'b0;
    endtask

    task automatic expect_beat(input logic [W-1:0] d, input logic [SW-1:0] s, input logic l);
        exp_q.push_back(d);
        exp_strb_q.push_back(s);
        exp_last_q.push_back(l);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        check_vec({tag, "_count"}, W'(got_q.size()), W'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                check_vec($sformatf("%s_data%0d", tag, i), got_q[i], exp_q[i]);
                check_vec($sformatf("%s_strb%0d", tag, i), W'(got_strb_q[i]), W'(exp_strb_q[i]));
                check_vec($sformatf("%s_last%0d", tag, i), W'(got_last_q[i]), W'(exp_last_q[i]));
            end
        end
        exp_q.delete(); exp_strb_q.delete(); exp_last_q.delete();
        got_q.delete(); got_strb_q.delete(); got_last_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0]  da, db, dp;
        logic [HW-1:0] ca, cb;
        logic [SW-1:0] low_strb;
        low_strb = {{(SW/2){1'b0}}, {(SW/2){1'b1}}};

        // Reset values, during and just after reset
        repeat (2) @(negedge clk);
        check_vec("rst_valid", W'(dst_valid), '0);
        check_vec("rst_data", dst_data, '0);
        check_vec("rst_strb", W'(dst_strb), '0);
        check_vec("rst_last", W'(dst_last), '0);
        rst_n = 1'b1;
        @(negedge clk);
        check_vec("post_rst_valid", W'(dst_valid), '0);

        // 4 cast beats of 1.0 -> 2 packed beats of 0x3C
        for (int i = 0; i < 4; i++) send(fill16(16'h3C00), i == 3, 1'b1);
        expect_beat({fill8(8'h3C), fill8(8'h3C)}, '1, 1'b0);
        expect_beat({fill8(8'h3C), fill8(8'h3C)}, '1, 1'b1);
        drain("cast4");

        // Rounding, NaN, infinity, subnormal and overflow lanes
        da = '0; ca = '0;
        da[16*0 +: 16] = 16'h3C80; ca[8*0 +: 8] = 8'h3C;
        da[16*1 +: 16] = 16'h3D80; ca[8*1 +: 8] = 8'h3E;
        da[16*2 +: 16] = 16'h7BFF; ca[8*2 +: 8] = 8'h7C;
        da[16*3 +: 16] = 16'h7E00; ca[8*3 +: 8] = 8'h7E;
        da[16*4 +: 16] = 16'hFC00; ca[8*4 +: 8] = 8'hFC;
        db = '0; cb = '0;
        db[16*0 +: 16] = 16'hBC80; cb[8*0 +: 8] = 8'hBC;
        db[16*1 +: 16] = 16'h0080; cb[8*1 +: 8] = 8'h00;
        db[16*2 +: 16] = 16'h0180; cb[8*2 +: 8] = 8'h02;
        db[16*3 +: 16] = 16'h7C01; cb[8*3 +: 8] = 8'h7E;
        db[16*4 +: 16] = 16'hFE00; cb[8*4 +: 8] = 8'hFE;
        db[16*5 +: 16] = 16'h7C00; cb[8*5 +: 8] = 8'h7C;
        db[16*6 +: 16] = 16'h3BFF; cb[8*6 +: 8] = 8'h3C;
        db[16*7 +: 16] = 16'hFBFF; cb[8*7 +: 8] = 8'hFC;
        send(da, 1'b0, 1'b1);
        send(db, 1'b1, 1'b1);
        expect_beat({cb, ca}, '1, 1'b1);
        drain("round");

        // Odd-length cast packet: tail beat carries only the low half
        send(fill16(16'h3C00), 1'b0, 1'b1);
        send(fill16(16'h4000), 1'b0, 1'b1);
        send(fill16(16'h4400), 1'b1, 1'b1);
        expect_beat({fill8(8'h40), fill8(8'h3C)}, '1, 1'b0);
        expect_beat({{HW{1'b0}}, fill8(8'h44)}, low_strb, 1'b1);
        drain("tail3");

        // Passthrough with random downstream stalls
        ready_mode = 1;
        for (int i = 0; i < 20; i++) begin
            dp = {8{32'($urandom())}};
            dp[31:0] = 32'(i);
            send(dp, i == 19, 1'b0);
            expect_beat(dp, '1, i == 19);
        end
        drain("pass_rand");
        ready_mode = 0;

        // cast_en changes inside a packet are ignored
        send(fill16(16'h3C00), 1'b0, 1'b1);
        send(fill16(16'h4000), 1'b0, 1'b0);
        send(fill16(16'h4400), 1'b0, 1'b0);
        send(fill16(16'h4800), 1'b1, 1'b0);
        expect_beat({fill8(8'h40), fill8(8'h3C)}, '1, 1'b0);
        expect_beat({fill8(8'h48), fill8(8'h44)}, '1, 1'b1);
        da = fill16(16'h1234);
        db = fill16(16'hABCD);
        send(da, 1'b0, 1'b0);
        send(db, 1'b1, 1'b1);
        expect_beat(da, '1, 1'b0);
        expect_beat(db, '1, 1'b1);
        drain("mode_hold");

        // Clear while a beat is held at the output and the packer is half full
        ready_mode = 2;
        @(negedge clk);
        dp = fill16(16'h5A5A);
        send(dp, 1'b1, 1'b0);
        send(fill16(16'h3C00), 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check_vec("hold_valid", W'(dst_valid), W'(1));
        check_vec("hold_data", dst_data, dp);
        check_vec("hold_last", W'(dst_last), W'(1));
        @(negedge clk);
        check_vec("hold_data_stable", dst_data, dp);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_vec("clear_valid", W'(dst_valid), '0);
        check_vec("clear_data", dst_data, '0);
        check_vec("clear_strb", W'(dst_strb), '0);
        ready_mode = 0;
        send(fill16(16'h4000), 1'b0, 1'b1);
        send(fill16(16'h4400), 1'b1, 1'b1);
        expect_beat({fill8(8'h44), fill8(8'h40)}, '1, 1'b1);
        drain("after_clear");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
